// File: rtl/count_seq_monitor.sv
// -----------------------------------------------------------------------------
// count_seq_monitor
//
// Watches a free-running WIDTH-bit synchronous T counter from the outside and
// checks every clock that the count moved by exactly t_prev (modulo 2^WIDTH).
// Reports wraps (all-ones -> zero), a programmable compare match, and step
// errors. After ERR_LIMIT mismatches the monitor parks in FAULT until clr/rst.
//
// Ports
//   clk          system clock, rising edge active
//   rst          asynchronous active-low reset
//   t_in         toggle-enable seen by the counter
//   q_in         counter value
//   clr          synchronous clear of counters, sticky error and FSM
//   cmp_en       enable compare-match detection
//   cmp_val      compare value
//   locked       FSM is in LOCKED
//   fault        FSM is in FAULT
//   wrap_pulse   one cycle per all-ones -> zero step
//   wrap_count   saturating wrap counter
//   match_pulse  one cycle when the count enters cmp_val
//   err_pulse    one cycle per step mismatch
//   err_sticky   set on first mismatch, cleared by rst/clr
//   err_count    saturating mismatch counter
// -----------------------------------------------------------------------------
module count_seq_monitor #(
   parameter int WIDTH     = 3,
   parameter int WRAP_CW   = 8,
   parameter int ERR_CW    = 4,
   parameter int ERR_LIMIT = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               t_in,
   input  logic [WIDTH-1:0]   q_in,
   input  logic               clr,
   input  logic               cmp_en,
   input  logic [WIDTH-1:0]   cmp_val,
   output logic               locked,
   output logic               fault,
   output logic               wrap_pulse,
   output logic [WRAP_CW-1:0] wrap_count,
   output logic               match_pulse,
   output logic               err_pulse,
   output logic               err_sticky,
   output logic [ERR_CW-1:0]  err_count
);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_LOCKED   = 2'd1,
      ST_FAULT    = 2'd2
   } state_t;

   state_t               r_state;
   logic [WIDTH-1:0]     r_q_prev;
   logic                 r_t_prev;
   logic                 r_locked;
   logic                 r_fault;
   logic                 r_wrap_pulse;
   logic [WRAP_CW-1:0]   r_wrap_count;
   logic                 r_match_pulse;
   logic                 r_err_pulse;
   logic                 r_err_sticky;
   logic [ERR_CW-1:0]    r_err_count;

   logic [WIDTH-1:0]     w_exp;
   logic                 w_step_ok;
   logic                 w_wrap;
   logic                 w_match;
   logic [ERR_CW-1:0]    w_err_next;
   logic [WRAP_CW-1:0]   w_wrap_next;
   logic                 w_err_limit_hit;

   function automatic logic [WRAP_CW-1:0] sat_inc_wrap(input logic [WRAP_CW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [ERR_CW-1:0] sat_inc_err(input logic [ERR_CW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Expected count: previous value advanced by the previous toggle-enable.
   assign w_exp           = r_t_prev ? r_q_prev + WIDTH'(1) : r_q_prev;
   assign w_step_ok       = (q_in == w_exp);
   // A wrap is always also a correct step, so it never coincides with an error.
   assign w_wrap          = r_t_prev && (&r_q_prev) && (q_in == '0);
   // Requiring a change of value stops a count parked on cmp_val re-firing.
   assign w_match         = cmp_en && (q_in == cmp_val) && (q_in != r_q_prev);
   assign w_err_next      = sat_inc_err(r_err_count);
   assign w_wrap_next     = sat_inc_wrap(r_wrap_count);
   assign w_err_limit_hit = (w_err_next >= ERR_CW'(ERR_LIMIT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_UNLOCKED;
         r_q_prev      <= '0;
         r_t_prev      <= 1'b0;
         r_locked      <= 1'b0;
         r_fault       <= 1'b0;
         r_wrap_pulse  <= 1'b0;
         r_wrap_count  <= '0;
         r_match_pulse <= 1'b0;
         r_err_pulse   <= 1'b0;
         r_err_sticky  <= 1'b0;
         r_err_count   <= '0;
      end else begin
         // The sample pipeline runs in every state, including during clr,
         // so the first locked edge already has a valid expectation.
         r_q_prev      <= q_in;
         r_t_prev      <= t_in;
         r_wrap_pulse  <= 1'b0;
         r_match_pulse <= 1'b0;
         r_err_pulse   <= 1'b0;

         if (clr) begin
            r_state      <= ST_UNLOCKED;
            r_locked     <= 1'b0;
            r_fault      <= 1'b0;
            r_wrap_count <= '0;
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
         end else begin
            case (r_state)
               ST_UNLOCKED: begin
                  r_state  <= ST_LOCKED;
                  r_locked <= 1'b1;
               end
               ST_LOCKED: begin
                  r_match_pulse <= w_match;
                  if (w_step_ok) begin
                     if (w_wrap) begin
                        r_wrap_pulse <= 1'b1;
                        r_wrap_count <= w_wrap_next;
                     end
                  end else begin
                     // Resync is implicit: q_prev takes this q_in regardless.
                     r_err_pulse  <= 1'b1;
                     r_err_sticky <= 1'b1;
                     r_err_count  <= w_err_next;
                     if (w_err_limit_hit) begin
                        r_state  <= ST_FAULT;
                        r_locked <= 1'b0;
                        r_fault  <= 1'b1;
                     end
                  end
               end
               ST_FAULT: begin
                  r_fault <= 1'b1;
               end
               default: begin
                  r_state  <= ST_UNLOCKED;
                  r_locked <= 1'b0;
                  r_fault  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign locked      = r_locked;
   assign fault       = r_fault;
   assign wrap_pulse  = r_wrap_pulse;
   assign wrap_count  = r_wrap_count;
   assign match_pulse = r_match_pulse;
   assign err_pulse   = r_err_pulse;
   assign err_sticky  = r_err_sticky;
   assign err_count   = r_err_count;

endmodule

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
- Downstream consumer of the 3-bit synchronous T counter. Samples the counter's toggle-enable and count value every clock and checks that the count steps correctly modulo 2^WIDTH.
- Produces wrap (terminal-count) events, a programmable compare-match event, and error reporting for the system controller.
- Sits beside the counter on the same clock, with no handshake back to it.

Parameters:
- WIDTH, 3, width of the monitored count value.
- WRAP_CW, 8, width of the wrap event counter (saturating).
- ERR_CW, 4, width of the error counter (saturating).
- ERR_LIMIT, 3, number of mismatches that forces FAULT; legal range 1..2^ERR_CW-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset; 0 resets, 1 runs.
- t_in  in  1  toggle-enable as driven into the counter.
- q_in  in  WIDTH  counter output q.
- clr  in  1  synchronous clear of counters, sticky error and FSM; returns the FSM to UNLOCKED.
- cmp_en  in  1  enables compare-match detection.
- cmp_val  in  WIDTH  compare value.
- locked  out  1  1 while the FSM is in LOCKED.
- fault  out  1  1 while the FSM is in FAULT.
- wrap_pulse  out  1  one-cycle pulse on each all-ones to zero step.
- wrap_count  out  WRAP_CW  number of wraps, saturating.
- match_pulse  out  1  one-cycle pulse when the count enters cmp_val.
- err_pulse  out  1  one-cycle pulse on each step mismatch.
- err_sticky  out  1  set on first mismatch; cleared only by rst or clr.
- err_count  out  ERR_CW  number of mismatches, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to UNLOCKED.
  - All outputs 0.
  - Internal q_prev=0, t_prev=0.
- Sampling:
  - Every rising edge registers q_in into q_prev and t_in into t_prev, in all states.
  - Expected value at edge k: exp = t_prev ? (q_prev+1) mod 2^WIDTH : q_prev.
- All outputs are registered. An event detected at edge k is visible from edge k until edge k+1, then pulses return to 0.
- FSM states:
  - UNLOCKED (no checks):
    - The first edge out of reset or clr captures the sample and moves to LOCKED.
    - Pulses are not generated in this state.
  - LOCKED: checks at every edge.
    - q_in==exp: no error.
      - wrap_pulse=1 when t_prev=1, q_prev=all-ones, q_in=0.
      - wrap_count increments unless it is at max.
    - q_in!=exp: err_pulse=1, err_sticky=1, err_count increments (saturating).
      - If the new err_count >= ERR_LIMIT, go to FAULT.
      - Otherwise stay LOCKED and resynchronise: the next expectation is based on the q_in just sampled.
  - FAULT:
    - No checks and no pulses.
    - fault=1, locked=0; counters hold.
    - Leaves only via clr or rst.
- Match:
  - Condition for match_pulse=1: LOCKED, cmp_en=1, q_in==cmp_val, q_in!=q_prev.
  - A count held at cmp_val with t=0 gives one pulse only.
  - match_pulse is evaluated independently of the error check; a mismatched step that lands on cmp_val still matches.
- clr:
  - Synchronous, and has priority over all other edge-k actions.
  - Clears the counters, err_sticky and the pulses; FSM goes to UNLOCKED.
  - Still captures q_prev/t_prev at the same edge.
- Simultaneous events: wrap_pulse and match_pulse may assert in the same cycle (cmp_val=0 on a wrap). wrap_pulse and err_pulse are mutually exclusive.
- Reset mid-operation: immediate, with no partial pulse completion. Re-lock takes one edge after rst rises.
- Saturation: wrap_count stops at 2^WRAP_CW-1 and err_count stops at 2^ERR_CW-1; neither wraps.

Test Plan:
- rst=0 for 12 ns, then t=1 free-running with a 10 ns clock for 200 ns → locked=1 after the first edge; err_count=0; wrap_pulse every 8 cycles; wrap_count=2 by 180 ns.
- Same stimulus with cmp_en=1, cmp_val=5 → match_pulse once per 8-cycle period, exactly on the edge where q becomes 5. With t held at 0 while q=5 → no further pulses.
- Force q_in from 3 to 6 once while t=1 → err_pulse one cycle, err_sticky=1, err_count=1, still locked. The next correct step (6→7) gives no error.
- Three injected mismatches with ERR_LIMIT=3 → fault=1, locked=0 after the third. Later wraps leave wrap_count unchanged. clr → UNLOCKED, then LOCKED one edge later, with err_count=0 and err_sticky=0.
- Pull rst low asynchronously mid-count (q=6) between clock edges → all outputs 0 immediately. Release → re-lock with no spurious err_pulse or wrap_pulse.
- Run 260 wraps with WRAP_CW=8 → wrap_count saturates at 255 and wrap_pulse continues.
